// File: rtl/raspi_link.sv
// ---------------------------------------------------------------------------
// raspi_link
// Raspberry Pi side of the 9-bit parallel host link.
//
// The host strobe, direction and data pins are synchronised into the clk
// domain. A rising strobe with dir=1 delivers one word to the decoder, which
// handles endpoint selection and data bytes. A rising strobe with dir=0
// consumes the word shown on raspi_dat_out, which is the head of the TX FIFO
// (0x1ff when the FIFO is empty).
//
// Optional build macro: RASPI_LINK_LINKTEST_EN
//   When defined, a direct select of endpoint 0x00 (word 0x100) enters a
//   link-test mode. In that mode every data byte a is answered in the TX FIFO
//   with {1'b0, ((a*33)^7) & 8'hff}.
//
// Parameters
//   TX_DEPTH_LOG2  log2 of TX FIFO depth in 9-bit words
//   SYNC_STAGES    synchroniser flops per host pin (>= 2)
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   raspi_clk        host strobe, transfer on rising edge
//   raspi_dir        1: host drives bus, 0: FPGA drives bus
//   raspi_dat_in     bus value seen on the pins
//   raspi_dat_out    value driven onto the bus (TX FIFO head or 0x1ff)
//   raspi_dat_oe     bus output enable
//   rx_ep            selected endpoint
//   rx_ep_open       an endpoint is selected
//   rx_sel           one-cycle pulse on endpoint selection
//   rx_valid         one-cycle pulse, rx_data valid
//   rx_data          host data byte
//   tx_valid/tx_data endpoint push into the TX FIFO (bit 8 = control word)
//   tx_ready         TX FIFO not full
//   tx_overflow      sticky, a push was dropped
// ---------------------------------------------------------------------------
// Decoder states
//   state    | meaning
//   ST_IDLE  | no endpoint selected, data bytes ignored
//   ST_OPEN  | endpoint selected, data bytes delivered on rx_valid
//   ST_ESC   | 0x1ff seen; next word is a resync (0x0ff) or escaped select
//   ST_LTEST | link-test mode (only with RASPI_LINK_LINKTEST_EN)
// ---------------------------------------------------------------------------
module raspi_link #(
  parameter int TX_DEPTH_LOG2 = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raspi_clk,
  input  logic       raspi_dir,
  input  logic [8:0] raspi_dat_in,
  output logic [8:0] raspi_dat_out,
  output logic       raspi_dat_oe,
  output logic [7:0] rx_ep,
  output logic       rx_ep_open,
  output logic       rx_sel,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [8:0] tx_data,
  output logic       tx_overflow
);

  localparam int DEPTH = 1 << TX_DEPTH_LOG2;

  localparam logic [8:0] WORD_ESC    = 9'h1ff;
  localparam logic [8:0] WORD_RESYNC = 9'h0ff;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OPEN = 2'd1;
  localparam logic [1:0] ST_ESC  = 2'd2;
`ifdef RASPI_LINK_LINKTEST_EN
  localparam logic [1:0] ST_LTEST = 2'd3;
  localparam logic [8:0] WORD_LTEST = 9'h100;
`endif

  localparam logic [TX_DEPTH_LOG2:0]   CNT_FULL = (TX_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [TX_DEPTH_LOG2:0]   CNT_ONE  = (TX_DEPTH_LOG2 + 1)'(1);
  localparam logic [TX_DEPTH_LOG2-1:0] PTR_ONE  = TX_DEPTH_LOG2'(1);

  // -------------------------------------------------------------------------
  // Pin synchronisers and strobe edge detection
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0]      clk_sync;
  logic [SYNC_STAGES-1:0]      dir_sync_chain;
  logic [SYNC_STAGES-1:0][8:0] dat_sync;
  logic                        clk_dly;
  logic                        clk_s;
  logic                        dir_s;
  logic [8:0]                  dat_s;

  logic                        strobe_q;
  logic                        dir_q;
  logic [8:0]                  word_q;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dir_s = dir_sync_chain[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // The strobe chain and its delayed copy reset to 1 so that a strobe held
  // high across reset is not taken as a new edge; detection re-arms only
  // once a low level has travelled through the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync       <= '1;
      clk_dly        <= 1'b1;
      dir_sync_chain <= '0;
      dat_sync       <= '0;
      strobe_q       <= 1'b0;
      dir_q          <= 1'b0;
      word_q         <= '0;
      raspi_dat_oe   <= 1'b0;
    end else begin
      clk_sync       <= {clk_sync[SYNC_STAGES-2:0], raspi_clk};
      dir_sync_chain <= {dir_sync_chain[SYNC_STAGES-2:0], raspi_dir};
      dat_sync       <= {dat_sync[SYNC_STAGES-2:0], raspi_dat_in};
      clk_dly        <= clk_s;
      strobe_q       <= clk_s & ~clk_dly;
      dir_q          <= dir_s;
      word_q         <= dat_s;
      raspi_dat_oe   <= ~dir_s;
    end
  end

  logic wr_stb;
  logic rd_stb;

  assign wr_stb = strobe_q & dir_q;
  assign rd_stb = strobe_q & ~dir_q;

  // -------------------------------------------------------------------------
  // Word decoder
  // -------------------------------------------------------------------------
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] ep_nxt;
  logic [7:0] data_nxt;
  logic       open_nxt;
  logic       sel_nxt;
  logic       valid_nxt;
  logic       flush;
  logic       int_push;
  logic [8:0] int_word;

  always_comb begin
    state_nxt = state;
    ep_nxt    = rx_ep;
    data_nxt  = rx_data;
    open_nxt  = rx_ep_open;
    sel_nxt   = 1'b0;
    valid_nxt = 1'b0;
    flush     = 1'b0;
    int_push  = 1'b0;
    int_word  = '0;
    if (wr_stb) begin
      if (word_q == WORD_ESC) begin
        state_nxt = ST_ESC;
      end else if (state == ST_ESC) begin
        if (word_q == WORD_RESYNC) begin
          state_nxt = ST_IDLE;
          open_nxt  = 1'b0;
          flush     = 1'b1;
        end else begin
          // escaped select: any word, including data-range values
          state_nxt = ST_OPEN;
          ep_nxt    = word_q[7:0];
          open_nxt  = 1'b1;
          sel_nxt   = 1'b1;
        end
      end else if (word_q[8]) begin
`ifdef RASPI_LINK_LINKTEST_EN
        if (word_q == WORD_LTEST) begin
          state_nxt = ST_LTEST;
          ep_nxt    = 8'h00;
          open_nxt  = 1'b1;
          int_push  = 1'b1;
          int_word  = WORD_LTEST;
        end else
`endif
        begin
          state_nxt = ST_OPEN;
          ep_nxt    = word_q[7:0];
          open_nxt  = 1'b1;
          sel_nxt   = 1'b1;
        end
      end else begin
        if (state == ST_OPEN) begin
          valid_nxt = 1'b1;
          data_nxt  = word_q[7:0];
        end
`ifdef RASPI_LINK_LINKTEST_EN
        if (state == ST_LTEST) begin
          // a*33 mod 256 == a + (a << 5) mod 256
          int_push = 1'b1;
          int_word = {1'b0, (word_q[7:0] + {word_q[2:0], 5'b0}) ^ 8'h07};
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rx_ep      <= '0;
      rx_ep_open <= 1'b0;
      rx_sel     <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
    end else begin
      state      <= state_nxt;
      rx_ep      <= ep_nxt;
      rx_ep_open <= open_nxt;
      rx_sel     <= sel_nxt;
      rx_valid   <= valid_nxt;
      rx_data    <= data_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // TX FIFO
  // -------------------------------------------------------------------------
  logic [8:0]               mem [DEPTH];
  logic [TX_DEPTH_LOG2-1:0] wr_ptr;
  logic [TX_DEPTH_LOG2-1:0] rd_ptr;
  logic [TX_DEPTH_LOG2:0]   count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [8:0]               push_word;
  logic                     push_ok;
  logic                     pop_ok;
  logic                     drop;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  assign tx_ready   = ~fifo_full;

  // Internal link-test words win over the endpoint in the same cycle.
  assign push_word = int_push ? int_word : tx_data;
  assign push_ok   = (int_push | tx_valid) & ~fifo_full & ~flush;
  assign pop_ok    = rd_stb & ~fifo_empty & ~flush;
  assign drop      = (tx_valid & (int_push | fifo_full)) | (int_push & fifo_full);

  assign raspi_dat_out = fifo_empty ? WORD_ESC : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (drop) begin
        tx_overflow <= 1'b1;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop_ok) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        case ({push_ok, pop_ok})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_raspi_link.sv
module tb_raspi_link;

  localparam int S     = 2;
  localparam int LOG2  = 8;
  localparam int DEPTH = 1 << LOG2;
`ifdef RASPI_LINK_LINKTEST_EN
  localparam bit LT = 1'b1;
`else
  localparam bit LT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raspi_clk = 1'b0;
  logic       raspi_dir = 1'b0;
  logic [8:0] raspi_dat_in = '0;
  logic [8:0] raspi_dat_out;
  logic       raspi_dat_oe;
  logic [7:0] rx_ep;
  logic       rx_ep_open;
  logic       rx_sel;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [8:0] tx_data = '0;
  logic       tx_overflow;

  raspi_link #(.TX_DEPTH_LOG2(LOG2), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset),
    .raspi_clk(raspi_clk), .raspi_dir(raspi_dir),
    .raspi_dat_in(raspi_dat_in), .raspi_dat_out(raspi_dat_out),
    .raspi_dat_oe(raspi_dat_oe),
    .rx_ep(rx_ep), .rx_ep_open(rx_ep_open), .rx_sel(rx_sel),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // cycle stamp and pulse monitor (sampled on the falling edge)
  int         cyc = 0;
  int         sel_cnt = 0, valid_cnt = 0;
  int         sel_cyc = 0, valid_cyc = 0;
  logic [7:0] sel_ep = '0, valid_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_sel) begin
      sel_cnt++;
      sel_cyc = cyc;
      sel_ep  = rx_ep;
    end
    if (rx_valid) begin
      valid_cnt++;
      valid_cyc  = cyc;
      valid_data = rx_data;
    end
  end

  // reference model of the link protocol
  logic [8:0] tx_q[$];
  bit         m_ovf;
  bit         m_open;
  bit         m_esc;
  bit         m_ltest;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    m_ovf   = 1'b0;
    m_open  = 1'b0;
    m_esc   = 1'b0;
    m_ltest = 1'b0;
  endtask

  task automatic model_push(input logic [8:0] w);
    if (tx_q.size() < DEPTH) tx_q.push_back(w);
    else m_ovf = 1'b1;
  endtask

  task automatic push(input logic [8:0] w);
    @(negedge clk);
    check("tx_ready", tx_ready, (tx_q.size() < DEPTH));
    tx_valid = 1'b1;
    tx_data  = w;
    @(negedge clk);
    tx_valid = 1'b0;
    model_push(w);
    check("head_after_push", raspi_dat_out, tx_q[0]);
    check("tx_overflow", tx_overflow, m_ovf);
  endtask

  task automatic host_write(input logic [8:0] w);
    bit         exp_sel, exp_valid;
    logic [7:0] exp_ep, exp_data;
    int         s0, v0, r;
    exp_sel   = 1'b0;
    exp_valid = 1'b0;
    exp_ep    = '0;
    exp_data  = '0;
    if (w == 9'h1ff) begin
      m_esc = 1'b1;
    end else if (m_esc) begin
      m_esc = 1'b0;
      if (w == 9'h0ff) begin
        m_open  = 1'b0;
        m_ltest = 1'b0;
        tx_q.delete();
      end else begin
        m_open  = 1'b1;
        m_ltest = 1'b0;
        exp_sel = 1'b1;
        exp_ep  = w[7:0];
      end
    end else if (w[8]) begin
      m_open = 1'b1;
      if (LT && w == 9'h100) begin
        m_ltest = 1'b1;
        model_push(9'h100);
      end else begin
        m_ltest = 1'b0;
        exp_sel = 1'b1;
        exp_ep  = w[7:0];
      end
    end else if (m_ltest) begin
      model_push(9'((((int'(w[7:0]) * 33) ^ 7) & 255)));
    end else if (m_open) begin
      exp_valid = 1'b1;
      exp_data  = w[7:0];
    end

    @(negedge clk);
    raspi_dir    = 1'b1;
    raspi_dat_in = w;
    repeat (S + 1) @(negedge clk);
    check("oe_during_write", raspi_dat_oe, 1'b0);
    s0 = sel_cnt;
    v0 = valid_cnt;
    r  = cyc;
    raspi_clk = 1'b1;
    repeat (S + 3) @(negedge clk);
    raspi_clk = 1'b0;
    repeat (S + 3) @(negedge clk);

    check("rx_sel_pulses", sel_cnt - s0, exp_sel);
    if (exp_sel) begin
      check("rx_sel_latency", sel_cyc - r, S + 2);
      check("rx_ep", sel_ep, exp_ep);
    end
    check("rx_valid_pulses", valid_cnt - v0, exp_valid);
    if (exp_valid) begin
      check("rx_valid_latency", valid_cyc - r, S + 2);
      check("rx_data", valid_data, exp_data);
    end
    check("rx_ep_open", rx_ep_open, m_open);
  endtask

  task automatic host_read();
    logic [8:0] exp;
    @(negedge clk);
    raspi_dir = 1'b0;
    repeat (S + 2) @(negedge clk);
    exp = (tx_q.size() != 0) ? tx_q[0] : 9'h1ff;
    check("oe_during_read", raspi_dat_oe, 1'b1);
    check("read_word", raspi_dat_out, exp);
    raspi_clk = 1'b1;
    repeat (S + 3) @(negedge clk);
    raspi_clk = 1'b0;
    repeat (S + 3) @(negedge clk);
    if (tx_q.size() != 0) void'(tx_q.pop_front());
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] w;
    int         op;
    model_reset();

    // reset values
    repeat (3) @(negedge clk);
    check("rst_oe", raspi_dat_oe, 1'b0);
    check("rst_dat_out", raspi_dat_out, 9'h1ff);
    check("rst_rx_ep", rx_ep, 8'h00);
    check("rst_ep_open", rx_ep_open, 1'b0);
    check("rst_rx_sel", rx_sel, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_overflow", tx_overflow, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    reset = 1'b0;

    // idle reads
    repeat (3) host_read();

    // select and data
    host_write(9'h105);
    host_write(9'h03c);
    host_write(9'h007);

    // resync flushes TX FIFO, then escaped select of endpoint 0
    push(9'h012);
    push(9'h134);
    host_write(9'h1ff);
    host_write(9'h0ff);
    host_read();
    host_write(9'h1ff);
    host_write(9'h000);
    host_write(9'h0a5);

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: push(9'($urandom_range(0, 511)));
        1: host_write({1'b0, 8'($urandom_range(0, 255))});
        2: begin
          w = {1'b1, 8'($urandom_range(0, 254))};
          host_write(w);
        end
        3: host_read();
        default: begin
          host_write(9'h1ff);
          host_write(9'($urandom_range(0, 511)));
        end
      endcase
    end

    // fill past full
    host_write(9'h1ff);
    host_write(9'h0ff);
    for (int i = 0; i < DEPTH + 1; i++) push(9'($urandom_range(0, 511)));
    check("full_tx_ready", tx_ready, 1'b0);
    check("full_overflow", tx_overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) host_read();
    host_read();
    host_write(9'h1ff);
    host_write(9'h0ff);
    check("overflow_survives_resync", tx_overflow, 1'b1);

`ifdef RASPI_LINK_LINKTEST_EN
    begin
      int v0, s0;
      host_write(9'h105);
      v0 = valid_cnt;
      s0 = sel_cnt;
      host_write(9'h100);
      for (int a = 8'h40; a <= 8'h7f; a++) host_write(9'(a));
      check("ltest_no_valid", valid_cnt - v0, 0);
      check("ltest_no_sel", sel_cnt - s0, 0);
      for (int i = 0; i < 66; i++) host_read();
      host_write(9'h107);
      host_write(9'h011);
    end
`endif

    // reset while the strobe is held high mid-write
    host_write(9'h105);
    begin
      int v0, s0;
      @(negedge clk);
      raspi_dir    = 1'b1;
      raspi_dat_in = 9'h055;
      repeat (S + 1) @(negedge clk);
      raspi_clk = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      v0 = valid_cnt;
      s0 = sel_cnt;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (8) @(negedge clk);
      check("midrst_no_valid", valid_cnt - v0, 0);
      check("midrst_no_sel", sel_cnt - s0, 0);
      check("midrst_ep_open", rx_ep_open, 1'b0);
      check("midrst_overflow", tx_overflow, 1'b0);
      raspi_clk = 1'b0;
      repeat (S + 3) @(negedge clk);
    end
    host_write(9'h107);
    host_write(9'h022);
    host_read();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/raspi_link.md
Name: raspi_link

Overview:
- Raspberry Pi side of the 9-bit parallel host link inside the c3demo top level.
- Synchronises the host strobe, direction and data pins into the system clock domain.
- Decodes control words and endpoint selection, and delivers host-to-FPGA bytes to the endpoint fabric.
- Serves FPGA-to-host words from an internal TX FIFO, with 0x1ff as idle filler when the FIFO is empty.

Parameters:
- TX_DEPTH_LOG2, 8, log2 of TX FIFO depth in 9-bit words (default 256 entries).
- SYNC_STAGES, 2, synchroniser flops on raspi_clk, raspi_dir and raspi_dat_in (minimum 2).

Ports:
- clk  in  1  system clock (CLK12MHZ domain).
- reset  in  1  synchronous, active-high reset.
- raspi_clk  in  1  host strobe; word transfer on rising edge.
- raspi_dir  in  1  1 = host drives bus (write); 0 = FPGA drives bus (read).
- raspi_dat_in  in  9  bus value as seen on the pins.
- raspi_dat_out  out  9  value the FPGA drives onto the bus.
- raspi_dat_oe  out  1  bus output enable.
- rx_ep  out  8  currently selected endpoint.
- rx_ep_open  out  1  an endpoint is selected.
- rx_sel  out  1  one-cycle pulse when an endpoint is selected.
- rx_valid  out  1  one-cycle pulse: rx_data is valid.
- rx_data  out  8  host data byte.
- tx_valid  in  1  endpoint pushes tx_data.
- tx_ready  out  1  TX FIFO not full.
- tx_data  in  9  word to return to the host; bit 8 marks control words.
- tx_overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset values: raspi_dat_oe=0, raspi_dat_out=0x1ff, rx_ep=0, rx_ep_open=0, rx_sel=0, rx_valid=0, rx_data=0, tx_overflow=0, TX FIFO empty, FSM in IDLE.
- Synchronisation: raspi_clk, raspi_dir and raspi_dat_in each pass through SYNC_STAGES flops. A strobe edge is detected when the last synchronised raspi_clk stage is 1 and the one-delayed copy is 0. Bus data is taken from the synchronised data on the edge-detect cycle.
- Host timing: the host holds data and dir stable ≥ SYNC_STAGES+1 clk cycles before raising raspi_clk.
- Output enable: raspi_dat_oe = !dir_sync. It drops to 0 one cycle after dir_sync rises, and is 0 whenever dir_sync=1.
- Read edge (dir_sync=0): raspi_dat_out always shows the FIFO head, or 0x1ff if the FIFO is empty. The edge pops the head if the FIFO is non-empty; if empty, nothing happens. raspi_dat_out updates the cycle after the pop.
- Write edge (dir_sync=1), word w, FSM:
  - Any state, w=0x1ff -> ESC.
  - IDLE or OPEN, w[8]=1 and w!=0x1ff -> OPEN; rx_ep=w[7:0]; rx_sel pulses.
  - OPEN, w[8]=0 -> rx_valid pulses; rx_data=w[7:0].
  - IDLE, w[8]=0 -> ignored.
  - ESC, w=0x0ff -> IDLE (resync): rx_ep_open=0 and the TX FIFO is flushed in the same cycle. A flush beats a simultaneous push or pop.
  - ESC, any other w -> OPEN; rx_ep=w[7:0]; rx_sel pulses. This is an escaped select; it allows selecting with a data-range word, e.g. 0x1ff,0x000.
- Latency: rx_valid and rx_sel assert exactly 1 cycle after the edge-detect cycle, so SYNC_STAGES+2 cycles after raspi_clk rises.
- TX push: when tx_valid=1 and the FIFO is not full, the word is written.
  - Push while full: word dropped, tx_overflow set. Only reset clears tx_overflow; resync does not.
  - Simultaneous push and pop: both occur, and the count is unchanged.
  - Push into an empty FIFO: visible on raspi_dat_out the next cycle.
- Reset mid-transfer: all state is cleared immediately and partial strobes are discarded. The edge detector is re-armed only after raspi_clk is seen low.

Optional Feature:
- Macro: RASPI_LINK_LINKTEST_EN.
- Defined: a direct select of endpoint 0x00 (word 0x100, not escaped) enters link-test mode.
  - The 0x100 is pushed to TX.
  - Each subsequent data byte a pushes {1'b0, ((a*33)^7)&8'hff} into TX.
  - No rx_sel or rx_valid pulses are produced while in link-test mode.
  - Internal pushes take priority over tx_valid in the same cycle; the external word is dropped and tx_overflow is set.
  - Any other select or a resync leaves link-test mode.
- Undefined: 0x100 is an ordinary select of endpoint 0.

Test Plan:
- Reset, then host reads 3 words with no pushes -> each reads 0x1ff, and raspi_dat_oe=1 while dir=0.
- Send 0x105 then 0x3c, 0x07 -> rx_sel pulse with rx_ep=0x05, then rx_valid twice with rx_data 0x3c then 0x07, each SYNC_STAGES+2 cycles after its strobe.
- Push 0x012, 0x134, then send 0x1ff,0x0ff, then read -> 0x1ff (FIFO flushed), and rx_ep_open=0. Send 0x1ff,0x000 -> rx_sel with rx_ep=0x00.
- Push 257 words with TX_DEPTH_LOG2=8 -> tx_ready low after 256, tx_overflow=1. Host reads 256 words in order, then reads 0x1ff.
- With RASPI_LINK_LINKTEST_EN: send 0x100 then bytes 0x40..0x7f -> reads return 0x100, then 0x040 -> 0x047, 0x041 -> 0x066, ..., then 0x1ff. No rx_valid pulses.
- Assert reset while raspi_clk is held high mid-write -> no rx_valid after reset, and the next full strobe is decoded normally.
